// File: rtl/alt_ddrx_buffer_pkg.sv
// alt_ddrx_buffer_pkg: shared types and constants for the DDR data buffer controller
package alt_ddrx_buffer_pkg;

    localparam int NUM_REQ = 2;

    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } req_idx_t;

    function automatic int read_latency(input int reg_output);
        return (reg_output != 0) ? 2 : 1;
    endfunction

endpackage

// File: rtl/alt_ddrx_rr_arbiter2.sv
// alt_ddrx_rr_arbiter2: two-input round-robin grant for the shared RAM write port
module alt_ddrx_rr_arbiter2
    import alt_ddrx_buffer_pkg::*;
(
    input  logic               ctl_clk,
    input  logic               ctl_reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               accept,
    output logic [NUM_REQ-1:0] grant,
    output req_idx_t           grant_idx
);

    req_idx_t last_grant;

    // a lone requester wins; on a tie the one that did not win last time goes
    always_comb begin
        grant_idx = (&req) ? ((last_grant == REQ0) ? REQ1 : REQ0) : (req[1] ? REQ1 : REQ0);
        grant     = req & ((grant_idx == REQ1) ? 2'b10 : 2'b01);
    end

    // history only moves when the granted word is actually written
    always_ff @(posedge ctl_clk) begin
        if (ctl_reset)
            last_grant <= REQ1;
        else if (accept)
            last_grant <= grant_idx;
    end

endmodule

// File: rtl/alt_ddrx_buffer_ctl.sv
// alt_ddrx_buffer_ctl: write arbitration, circular pointers, occupancy and read-latency tracking
module alt_ddrx_buffer_ctl
    import alt_ddrx_buffer_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 4,
    parameter int BUFFER_DEPTH = 2**ADDR_WIDTH,
    parameter int REG_OUTPUT   = 1
) (
    input  logic                  ctl_clk,
    input  logic                  ctl_reset,
    input  logic                  req0_valid,
    input  logic [DATA_WIDTH-1:0] req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  req1_ready,
    input  logic                  pop,
    output logic                  pop_ready,
    output logic                  write_valid,
    output logic [ADDR_WIDTH-1:0] write_address,
    output logic [DATA_WIDTH-1:0] write_data,
    output logic [ADDR_WIDTH-1:0] read_address,
    input  logic [DATA_WIDTH-1:0] read_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_src,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty
);

    localparam int                LAT     = read_latency(REG_OUTPUT);
    localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH+1)'(BUFFER_DEPTH);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

    logic [NUM_REQ-1:0]    grant;
    req_idx_t              grant_idx;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    req_idx_t              src_mem [BUFFER_DEPTH];
    logic [LAT-1:0]        vpipe;
    req_idx_t              spipe [LAT];

    alt_ddrx_rr_arbiter2 u_arb (
        .ctl_clk   (ctl_clk),
        .ctl_reset (ctl_reset),
        .req       ({req1_valid, req0_valid}),
        .accept    (write_valid),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign full         = (count == DEPTH_C);
    assign empty        = (count == '0);
    assign pop_ready    = ~empty;
    assign read_address = rd_ptr;
    assign out_valid    = vpipe[LAT-1];
    assign out_src      = spipe[LAT-1];
    assign out_data     = read_data;

    // the granted word goes straight to the RAM write port unless the buffer is full
    always_comb begin
        req0_ready    = grant[0] & ~full;
        req1_ready    = grant[1] & ~full;
        write_valid   = req0_ready | req1_ready;
        write_address = wr_ptr;
        write_data    = (grant_idx == REQ1) ? req1_data : req0_data;
        rd_en         = pop & ~empty;
    end

    // pointers wrap naturally because the depth is a power of two
    always_ff @(posedge ctl_clk) begin
        if (ctl_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (write_valid)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_en)
                rd_ptr <= rd_ptr + PTR_ONE;
            count <= (write_valid & ~rd_en) ? count + CNT_ONE :
                     (~write_valid & rd_en) ? count - CNT_ONE : count;
        end
    end

    // remember which requester wrote each slot so the tag can follow the data out
    always_ff @(posedge ctl_clk) begin
        if (write_valid)
            src_mem[wr_ptr] <= grant_idx;
    end

    // valid/tag delay line matching the RAM read latency; reset drops in-flight pops
    always_ff @(posedge ctl_clk) begin
        if (ctl_reset) begin
            vpipe <= '0;
            for (int i = 0; i < LAT; i++)
                spipe[i] <= REQ0;
        end else begin
            vpipe[0] <= rd_en;
            spipe[0] <= src_mem[rd_ptr];
            for (int i = 1; i < LAT; i++) begin
                vpipe[i] <= vpipe[i-1];
                spipe[i] <= spipe[i-1];
            end
        end
    end

endmodule

// File: tb/tb_alt_ddrx_buffer_ctl.sv
// tb_alt_ddrx_buffer_ctl: directed and randomized checks of the buffer controller against a queue model
module tb_alt_ddrx_buffer_ctl;

    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int LAT   = 2;

    logic          ctl_clk    = 1'b0;
    logic          ctl_reset  = 1'b1;
    logic          req0_valid = 1'b0;
    logic          req1_valid = 1'b0;
    logic          pop        = 1'b0;
    logic [DW-1:0] req0_data  = '0;
    logic [DW-1:0] req1_data  = '0;
    logic [DW-1:0] read_data;
    logic          req0_ready, req1_ready, pop_ready, write_valid, out_valid, out_src, full, empty;
    logic [AW-1:0] write_address, read_address;
    logic [DW-1:0] write_data, out_data;
    logic [AW:0]   count;

    int checks   = 0;
    int failures = 0;

    always #5 ctl_clk = ~ctl_clk;

    alt_ddrx_buffer_ctl dut (
        .ctl_clk       (ctl_clk),
        .ctl_reset     (ctl_reset),
        .req0_valid    (req0_valid),
        .req0_data     (req0_data),
        .req0_ready    (req0_ready),
        .req1_valid    (req1_valid),
        .req1_data     (req1_data),
        .req1_ready    (req1_ready),
        .pop           (pop),
        .pop_ready     (pop_ready),
        .write_valid   (write_valid),
        .write_address (write_address),
        .write_data    (write_data),
        .read_address  (read_address),
        .read_data     (read_data),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_src       (out_src),
        .count         (count),
        .full          (full),
        .empty         (empty)
    );

    // RAM with registered address and registered output (two-cycle read)
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] q1, q2;
    always @(posedge ctl_clk) begin
        if (write_valid)
            mem[write_address] <= write_data;
        q1 <= mem[read_address];
        q2 <= q1;
    end
    assign read_data = q2;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // behavioural model: FIFO of stored words plus a list of outputs due on given cycles
    typedef struct { logic [DW-1:0] d; logic s; } ent_t;
    typedef struct { logic [DW-1:0] d; logic s; int due; } pend_t;
    ent_t  mq [$];
    pend_t pq [$];
    int    wp = 0, rp = 0, cyc = 0, n;
    logic  last = 1'b1;
    logic  g, acc, pa, eov;

    always @(negedge ctl_clk) begin
        cyc++;
        if (ctl_reset) begin
            mq.delete();
            pq.delete();
            wp   = 0;
            rp   = 0;
            last = 1'b1;
        end else begin
            n   = mq.size();
            g   = (req0_valid && req1_valid) ? ~last : req1_valid;
            acc = (req0_valid || req1_valid) && (n < DEPTH);
            chk("req0_ready", req0_ready, acc && !g);
            chk("req1_ready", req1_ready, acc && g);
            chk("write_valid", write_valid, acc);
            if (acc) begin
                chk("write_address", write_address, wp);
                chk("write_data", write_data, g ? req1_data : req0_data);
            end
            chk("count", count, n);
            chk("empty", empty, n == 0);
            chk("full", full, n == DEPTH);
            chk("pop_ready", pop_ready, n != 0);
            chk("read_address", read_address, rp);
            eov = (pq.size() > 0) && (pq[0].due == cyc);
            chk("out_valid", out_valid, eov);
            if (eov) begin
                chk("out_data", out_data, pq[0].d);
                chk("out_src", out_src, pq[0].s);
                void'(pq.pop_front());
            end
            pa = pop && (n > 0);
            if (pa) begin
                pq.push_back('{mq[0].d, mq[0].s, cyc + LAT});
                void'(mq.pop_front());
                rp = (rp + 1) % DEPTH;
            end
            if (acc) begin
                mq.push_back('{g ? req1_data : req0_data, g});
                wp   = (wp + 1) % DEPTH;
                last = g;
            end
        end
    end

    task automatic tick;
        @(posedge ctl_clk);
        #1;
    endtask

    task automatic idle;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        pop        = 1'b0;
    endtask

    task automatic do_reset;
        idle();
        ctl_reset = 1'b1;
        tick();
        tick();
        ctl_reset = 1'b0;
    endtask

    logic [3:0] srcs;
    int         k;
    int         pw0, pw1, pp;

    initial begin
        do_reset();
        @(negedge ctl_clk);
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_pop_ready", pop_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_src", out_src, 0);
        chk("rst_write_valid", write_valid, 0);
        chk("rst_req0_ready", req0_ready, 0);
        chk("rst_req1_ready", req1_ready, 0);

        tick();
        req0_valid = 1'b1;
        req0_data  = 32'hA5A5A5A5;
        @(negedge ctl_clk);
        chk("single_waddr", write_address, 0);
        chk("single_ready", req0_ready, 1);
        tick();
        idle();
        pop = 1'b1;
        @(negedge ctl_clk);
        chk("single_count", count, 1);
        chk("single_pop_ready", pop_ready, 1);
        tick();
        pop = 1'b0;
        @(negedge ctl_clk);
        chk("single_early_valid", out_valid, 0);
        tick();
        @(negedge ctl_clk);
        chk("single_out_valid", out_valid, 1);
        chk("single_out_data", out_data, 32'hA5A5A5A5);
        chk("single_out_src", out_src, 0);
        tick();

        do_reset();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req0_data = 32'h100 + i;
            req1_data = 32'h200 + i;
            @(negedge ctl_clk);
            chk("tie_grant0", req0_ready, (i % 2) == 0);
            chk("tie_addr", write_address, i);
            tick();
        end
        idle();
        pop  = 1'b1;
        srcs = '0;
        k    = 0;
        for (int j = 0; j < 8; j++) begin
            if (j == 4)
                pop = 1'b0;
            @(negedge ctl_clk);
            if (out_valid && k < 4) begin
                srcs[k] = out_src;
                k++;
            end
            tick();
        end
        chk("tie_src_count", k, 4);
        chk("tie_src_seq", srcs, 4'b1010);

        do_reset();
        req0_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            req0_data = 32'h1000 + i;
            tick();
        end
        req0_data  = 32'h17;
        req1_valid = 1'b1;
        @(negedge ctl_clk);
        chk("fill_full", full, 1);
        chk("fill_count", count, 16);
        chk("fill_r0_blocked", req0_ready, 0);
        chk("fill_r1_blocked", req1_ready, 0);
        tick();
        req1_valid = 1'b0;
        pop        = 1'b1;
        @(negedge ctl_clk);
        chk("fill_hold", req0_ready, 0);
        tick();
        pop = 1'b0;
        @(negedge ctl_clk);
        chk("fill_after_pop_count", count, 15);
        chk("fill_17th_ready", req0_ready, 1);
        chk("fill_17th_wrap_addr", write_address, 0);
        tick();
        idle();

        do_reset();
        req0_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            req0_data = 32'h300 + i;
            tick();
        end
        req0_data = 32'h305;
        pop       = 1'b1;
        @(negedge ctl_clk);
        chk("sim_count_before", count, 5);
        chk("sim_raddr_before", read_address, 0);
        chk("sim_waddr_before", write_address, 5);
        tick();
        pop       = 1'b0;
        req0_data = 32'h306;
        @(negedge ctl_clk);
        chk("sim_count_after", count, 5);
        chk("sim_raddr_after", read_address, 1);
        chk("sim_waddr_after", write_address, 6);
        tick();
        idle();

        do_reset();
        pop = 1'b1;
        tick();
        pop = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(negedge ctl_clk);
            chk("empty_pop_no_valid", out_valid, 0);
            tick();
        end
        @(negedge ctl_clk);
        chk("empty_pop_raddr", read_address, 0);
        chk("empty_pop_count", count, 0);
        tick();
        req0_valid = 1'b1;
        req0_data  = 32'h55;
        tick();
        req0_valid = 1'b0;
        pop        = 1'b1;
        tick();
        pop       = 1'b0;
        ctl_reset = 1'b1;
        tick();
        ctl_reset = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(negedge ctl_clk);
            chk("rst_flush_no_valid", out_valid, 0);
            chk("rst_flush_count", count, 0);
            tick();
        end

        for (int c = 0; c < 4000; c++) begin
            case ((c / 300) % 3)
                0:       begin pw0 = 80; pw1 = 60; pp = 30; end
                1:       begin pw0 = 25; pw1 = 20; pp = 85; end
                default: begin pw0 = 50; pw1 = 50; pp = 70; end
            endcase
            req0_valid = $urandom_range(0, 99) < pw0;
            req1_valid = $urandom_range(0, 99) < pw1;
            req0_data  = $urandom;
            req1_data  = $urandom;
            pop        = $urandom_range(0, 99) < pp;
            ctl_reset  = $urandom_range(0, 999) == 0;
            tick();
        end
        ctl_reset = 1'b0;
        idle();
        for (int j = 0; j < 5; j++)
            tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
